cbc_ctl_out: RTL and testbench

- Output-side controller of the AES CBC datapath; counterpart of the input controller.
- Takes 128-bit result blocks from the AES core and serialises them into 34-bit tagged words for the output FIFO, using the same framing as the input stream: tag 01 = header, 00 = data, 10 = last word.
- Returns the most recent result block as the CBC chain value.
- Issues a per-block done pulse so the input side can release the next block.

---
 rtl/aes_ctl_pkg.sv | 39 +++
 rtl/blk_serializer.sv | 43 ++++
 rtl/cbc_ctl_out.sv | 141 ++++++++++++++
 tb/tb_cbc_ctl_out.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctl_pkg.sv
// Shared constants, state encoding and key-code mapping for the AES CBC controllers.
// CBC_CTL_OUT_CHKSUM_EN adds the TRAIL state used for the XOR trailer word.
package aes_ctl_pkg;

  localparam int DW = 32;
  localparam int BW = 128;
  localparam int LW = 8;

  localparam logic [1:0] TAG_HDR = 2'b01;
  localparam logic [1:0] TAG_DAT = 2'b00;
  localparam logic [1:0] TAG_END = 2'b10;

  localparam logic [2:0] KCODE_128 = 3'b101;
  localparam logic [2:0] KCODE_192 = 3'b100;
  localparam logic [2:0] KCODE_256 = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WAIT,
`ifdef CBC_CTL_OUT_CHKSUM_EN
    SEND,
    TRAIL
`else
    SEND
`endif
  } state_e;

  // Key mode 3 is illegal and yields an all-zero code.
  function automatic logic [2:0] kcode(input logic [1:0] key_mode);
    case (key_mode)
      2'd0:    kcode = KCODE_128;
      2'd1:    kcode = KCODE_192;
      2'd2:    kcode = KCODE_256;
      default: kcode = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/blk_serializer.sv
// 128-to-32 shift buffer: loads a result block and presents one word at a time,
// advancing only when the controller actually writes a word.
module blk_serializer
  import aes_ctl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [BW-1:0] blk_i,
  input  logic          adv_i,
  output logic [DW-1:0] word_o,
  output logic          last_o
);

  logic [BW-1:0] buf_q, buf_d;
  logic [1:0]    idx_q, idx_d;

  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    if (load_i) begin
      buf_d = blk_i;
      idx_d = 2'd0;
    end else if (adv_i) begin
      buf_d = {{DW{1'b0}}, buf_q[BW-1:DW]};
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      idx_q <= '0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
    end
  end

  assign word_o = buf_q[DW-1:0];
  assign last_o = (idx_q == 2'(BW / DW - 1));

endmodule

// File: rtl/cbc_ctl_out.sv
// Output controller of the AES CBC datapath: frames result blocks into tagged FIFO words.
// Define CBC_CTL_OUT_CHKSUM_EN to append an XOR checksum trailer to every frame.
module cbc_ctl_out
  import aes_ctl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [7:0]    i_data_len,
  input  logic          i_mode,
  input  logic [1:0]    i_key_mode,
  input  logic          i_done_aes,
  input  logic [127:0]  i_data_out_aes,
  input  logic          i_full_fifo,
  output logic          o_wr_out,
  output logic [33:0]   o_data_out,
  output logic [127:0]  o_data_chain,
  output logic          o_done_data,
  output logic          o_busy,
  output logic          o_error
);

  state_e          state_q;
  logic [LW-1:0]   len_q;
  logic            mode_q;
  logic [1:0]      kmode_q;
  logic [LW-1:0]   cnt_q;
  logic            wr_q;
  logic [DW+1:0]   data_q;
  logic [BW-1:0]   chain_q;
  logic            done_q;
  logic            err_q;
`ifdef CBC_CTL_OUT_CHKSUM_EN
  logic [DW-1:0]   chk_q;
`endif

  logic [DW-1:0]   ser_word;
  logic            ser_last;
  logic            ser_load;
  logic            ser_adv;
  logic            last_frame_word;
  logic [1:0]      word_tag;

  assign ser_load        = (state_q == WAIT) && i_done_aes && !i_start;
  assign ser_adv         = (state_q == SEND) && !i_full_fifo && !i_start;
  assign last_frame_word = (cnt_q == len_q - 8'd1);
`ifdef CBC_CTL_OUT_CHKSUM_EN
  assign word_tag        = TAG_DAT;
`else
  assign word_tag        = last_frame_word ? TAG_END : TAG_DAT;
`endif

  blk_serializer u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ser_load),
    .blk_i  (i_data_out_aes),
    .adv_i  (ser_adv),
    .word_o (ser_word),
    .last_o (ser_last)
  );

  // A result block is only welcome in WAIT; anywhere else it is dropped and flagged.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      mode_q  <= 1'b0;
      kmode_q <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      chain_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CBC_CTL_OUT_CHKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      if (i_done_aes && state_q != WAIT) err_q <= 1'b1;
      if (i_start) begin
        state_q <= HDR;
        len_q   <= {i_data_len[LW-1:2], 2'b00};
        mode_q  <= i_mode;
        kmode_q <= i_key_mode;
        cnt_q   <= '0;
        err_q   <= (state_q != IDLE) || i_done_aes ||
                   (i_data_len[1:0] != 2'b00) || (i_key_mode == 2'd3);
`ifdef CBC_CTL_OUT_CHKSUM_EN
        chk_q   <= '0;
`endif
      end else begin
        case (state_q)
          HDR: if (!i_full_fifo) begin
            wr_q    <= 1'b1;
            data_q  <= {TAG_HDR, {(DW-LW-4){1'b0}}, kcode(kmode_q), mode_q, len_q};
            state_q <= (len_q == '0) ? IDLE : WAIT;
          end
          WAIT: if (i_done_aes) begin
            chain_q <= i_data_out_aes;
            state_q <= SEND;
          end
          SEND: if (!i_full_fifo) begin
            wr_q   <= 1'b1;
            data_q <= {word_tag, ser_word};
            cnt_q  <= cnt_q + 8'd1;
`ifdef CBC_CTL_OUT_CHKSUM_EN
            chk_q  <= chk_q ^ ser_word;
`endif
            if (ser_last) begin
              done_q <= 1'b1;
`ifdef CBC_CTL_OUT_CHKSUM_EN
              state_q <= last_frame_word ? TRAIL : WAIT;
`else
              state_q <= last_frame_word ? IDLE : WAIT;
`endif
            end
          end
`ifdef CBC_CTL_OUT_CHKSUM_EN
          TRAIL: if (!i_full_fifo) begin
            wr_q    <= 1'b1;
            data_q  <= {TAG_END, chk_q};
            state_q <= IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign o_wr_out     = wr_q;
  assign o_data_out   = data_q;
  assign o_data_chain = chain_q;
  assign o_done_data  = done_q;
  assign o_busy       = (state_q != IDLE);
  assign o_error      = err_q;

endmodule

// File: tb/tb_cbc_ctl_out.sv
// Self-checking bench for cbc_ctl_out: a frame-level model predicts every FIFO word,
// and directed scenarios pin headers, chain values and error flags with literals.
module tb_cbc_ctl_out;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [7:0]   i_data_len = '0;
  logic         i_mode = 1'b0;
  logic [1:0]   i_key_mode = '0;
  logic         i_done_aes = 1'b0;
  logic [127:0] i_data_out_aes = '0;
  logic         i_full_fifo = 1'b0;
  logic         o_wr_out;
  logic [33:0]  o_data_out;
  logic [127:0] o_data_chain;
  logic         o_done_data;
  logic         o_busy;
  logic         o_error;

  always #5 clk = ~clk;

  cbc_ctl_out dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_data_len     (i_data_len),
    .i_mode         (i_mode),
    .i_key_mode     (i_key_mode),
    .i_done_aes     (i_done_aes),
    .i_data_out_aes (i_data_out_aes),
    .i_full_fifo    (i_full_fifo),
    .o_wr_out       (o_wr_out),
    .o_data_out     (o_data_out),
    .o_data_chain   (o_data_chain),
    .o_done_data    (o_done_data),
    .o_busy         (o_busy),
    .o_error        (o_error)
  );

  typedef struct packed {
    logic [33:0] data;
    logic        done;
  } expEntry_t;

  expEntry_t    expQ[$];
  expEntry_t    curExp;
  int           checks = 0;
  int           errors = 0;
  logic [127:0] blkMem [0:3];
  logic         fullAtEdge = 1'b0;

  // The DUT acts on the falling edge; remember what it saw for the hold-on-full check.
  always @(negedge clk) fullAtEdge = i_full_fifo;

  // Compare process: every written word must be the next one the model predicts.
  always @(posedge clk) begin
    if (rst_n && fullAtEdge) begin
      checks++;
      if (o_wr_out) begin
        errors++;
        $display("[TB] FAIL hold_on_full: o_wr_out=%b required 0", o_wr_out);
      end
    end
    if (o_wr_out) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: data=%h required no write", o_data_out);
      end else begin
        curExp = expQ.pop_front();
        if (o_data_out !== curExp.data || o_done_data !== curExp.done) begin
          errors++;
          $display("[TB] FAIL word: data=%h done=%b required data=%h done=%b",
                   o_data_out, o_done_data, curExp.data, curExp.done);
        end
      end
    end else if (o_done_data) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_without_write: o_done_data=1 required 0");
    end
  end

  // Frame model: header, then every block word in order, optional XOR trailer.
  task automatic expectFrame(input logic [7:0] len, input logic mode, input logic [1:0] kmode);
    int          effLen;
    logic [2:0]  kc;
    logic [31:0] w;
    logic [31:0] xsum;
    logic [1:0]  tag;
    effLen = int'(len) - (int'(len) % 4);
    case (kmode)
      2'd0:    kc = 3'd5;
      2'd1:    kc = 3'd4;
      2'd2:    kc = 3'd3;
      default: kc = 3'd0;
    endcase
    expQ.push_back('{data: {2'b01, 20'd0, kc, mode, 8'(effLen)}, done: 1'b0});
    xsum = '0;
    for (int i = 0; i < effLen; i++) begin
      w = blkMem[i / 4][32 * (i % 4) +: 32];
      xsum = xsum ^ w;
`ifdef CBC_CTL_OUT_CHKSUM_EN
      tag = 2'b00;
`else
      tag = (i == effLen - 1) ? 2'b10 : 2'b00;
`endif
      expQ.push_back('{data: {tag, w}, done: (i % 4 == 3)});
    end
`ifdef CBC_CTL_OUT_CHKSUM_EN
    if (effLen > 0) expQ.push_back('{data: {2'b10, xsum}, done: 1'b0});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, required);
    end
  endtask

  // kind 0: a write, 1: a done pulse, 2: frame fully drained and idle.
  task automatic waitEvent(input int kind);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if ((kind == 0 && o_wr_out) || (kind == 1 && o_done_data) ||
          (kind == 2 && !o_busy && expQ.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL timeout: event kind %0d not seen, required within 60 cycles", kind);
    end
  endtask

  task automatic startFrame(input logic [7:0] len, input logic mode, input logic [1:0] kmode);
    i_start    = 1'b1;
    i_data_len = len;
    i_mode     = mode;
    i_key_mode = kmode;
    tick();
    i_start    = 1'b0;
  endtask

  task automatic sendBlock(input logic [127:0] blk);
    i_done_aes     = 1'b1;
    i_data_out_aes = blk;
    tick();
    i_done_aes     = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] len, input logic mode, input logic [1:0] kmode);
    expectFrame(len, mode, kmode);
    startFrame(len, mode, kmode);
    waitEvent(0);
    for (int b = 0; b < int'(len) / 4; b++) begin
      sendBlock(blkMem[b]);
      waitEvent(1);
    end
    waitEvent(2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    blkMem[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    blkMem[1] = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    blkMem[2] = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    blkMem[3] = 128'h55555555_AAAAAAAA_12345678_9ABCDEF0;

    repeat (3) tick();
    checkOutput("rst_wr",    o_wr_out, 0);
    checkOutput("rst_data",  o_data_out, 0);
    checkOutput("rst_chain", o_data_chain, 0);
    checkOutput("rst_done",  o_done_data, 0);
    checkOutput("rst_busy",  o_busy, 0);
    checkOutput("rst_err",   o_error, 0);
    rst_n = 1'b1;
    tick();

    // Basic single-block frame
    expectFrame(8'd4, 1'b1, 2'd0);
    startFrame(8'd4, 1'b1, 2'd0);
    waitEvent(0);
    checkOutput("hdr_basic", o_data_out, 34'h1_0000_0B04);
    sendBlock(blkMem[0]);
    waitEvent(1);
`ifdef CBC_CTL_OUT_CHKSUM_EN
    checkOutput("last_word_basic", o_data_out, 34'h0_00112233);
`else
    checkOutput("last_word_basic", o_data_out, 34'h2_00112233);
`endif
    checkOutput("chain_basic", o_data_chain, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    waitEvent(2);
    checkOutput("busy_after_basic", o_busy, 0);
    checkOutput("err_after_basic", o_error, 0);

    // Backpressure for three cycles after the first data word
    expectFrame(8'd4, 1'b1, 2'd0);
    startFrame(8'd4, 1'b1, 2'd0);
    waitEvent(0);
    sendBlock(blkMem[0]);
    tick();
    i_full_fifo = 1'b1;
    tick();
    checkOutput("busy_during_full", o_busy, 1);
    repeat (2) tick();
    i_full_fifo = 1'b0;
    waitEvent(1);
    checkOutput("chain_bp", o_data_chain, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    waitEvent(2);

    // Two-block frame
    blkMem[0] = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    blkMem[1] = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    applyStimulus(8'd8, 1'b0, 2'd1);
    checkOutput("chain_second", o_data_chain, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
    checkOutput("err_two_blk", o_error, 0);

    // Overrun while sending: extra block is dropped
    expectFrame(8'd4, 1'b0, 2'd2);
    startFrame(8'd4, 1'b0, 2'd2);
    waitEvent(0);
    sendBlock(blkMem[0]);
    sendBlock(128'h55555555_AAAAAAAA_12345678_9ABCDEF0);
    waitEvent(1);
    waitEvent(2);
    checkOutput("err_overrun", o_error, 1);
    checkOutput("chain_overrun", o_data_chain, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98);
    expectFrame(8'd4, 1'b0, 2'd0);
    startFrame(8'd4, 1'b0, 2'd0);
    checkOutput("err_cleared", o_error, 0);
    waitEvent(0);
    sendBlock(blkMem[0]);
    waitEvent(1);
    waitEvent(2);

    // Length not a multiple of four
    applyStimulus(8'd6, 1'b1, 2'd0);
    checkOutput("err_len6", o_error, 1);

    // Illegal key mode
    applyStimulus(8'd4, 1'b1, 2'd3);
    checkOutput("err_key3", o_error, 1);

    // Zero-length frame: header only
    applyStimulus(8'd0, 1'b0, 2'd0);
    checkOutput("err_len0", o_error, 0);

    // Asynchronous reset in the middle of SEND
    expectFrame(8'd8, 1'b0, 2'd1);
    startFrame(8'd8, 1'b0, 2'd1);
    waitEvent(0);
    sendBlock(blkMem[0]);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_wr",    o_wr_out, 0);
    checkOutput("rst_mid_busy",  o_busy, 0);
    checkOutput("rst_mid_chain", o_data_chain, 0);
    checkOutput("rst_mid_data",  o_data_out, 0);
    expQ.delete();
    tick();
    rst_n = 1'b1;
    tick();
    expectFrame(8'd4, 1'b0, 2'd2);
    startFrame(8'd4, 1'b0, 2'd2);
    waitEvent(0);
    checkOutput("hdr_after_rst", o_data_out, 34'h1_0000_0604);
    sendBlock(blkMem[0]);
    waitEvent(1);
    waitEvent(2);

    repeat (3) tick();
    checkOutput("exp_queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
